safe_lock_ctrl: RTL and testbench



---
 rtl/safe_box_pkg.sv | 20 ++
 rtl/alarm_hold_timer.sv | 42 ++++
 rtl/safe_lock_ctrl.sv | 128 ++++++++++++
 tb/tb_safe_lock_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/safe_box_pkg.sv
// Shared types and constants for the safe-box code-entry controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package safe_box_pkg;

  // Controller states; the outputs decode from the registered state.
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ALARM    = 2'd2
  } lock_state_t;

  // Default code width and the password loaded on reset.
  localparam int          SAFE_CODE_W       = 4;
  localparam logic [3:0]  SAFE_DEFAULT_CODE = 4'b0101;

  // Width of the consecutive-failure counter (MAX_FAIL is at most 7).
  localparam int          FAIL_W            = 3;

endpackage

// File: rtl/alarm_hold_timer.sv
// Counts the cycles spent in ALARM and flags the last one so the controller can relock.
// Latency: done is combinational from the count; count clears on start and outside run.
// Backpressure: none; free-running while run is high.
module alarm_hold_timer #(
  parameter int TICKS = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int            W    = $clog2(TICKS + 1);
  localparam logic [W-1:0]  LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // done marks the final ALARM cycle, giving exactly TICKS cycles of alarm.
  assign done = run && (cnt_q == LAST);

  // Next count: zero on entry and whenever idle, otherwise advance.
  always_comb begin
    cnt_d = '0;
    if (start) begin
      cnt_d = '0;
    end else if (run && !done) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Code-entry/lockout controller: unlocks on a password match, alarms after MAX_FAIL misses.
// Latency: every output is registered and follows the triggering edge by one cycle.
// Backpressure: none; each key_valid cycle is one entry. SAFE_LOCK_ALARM_TIMEOUT_EN adds a timed alarm exit.
module safe_lock_ctrl
  import safe_box_pkg::*;
#(
  parameter int                CODE_W       = SAFE_CODE_W,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(SAFE_DEFAULT_CODE),
  parameter int                MAX_FAIL     = 3,
  parameter int                ALARM_TICKS  = 500_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_valid,
  input  logic              set_mode,
  input  logic              lock_cmd,
  output logic              unlocked,
  output logic              alarm,
  output logic              err_pulse,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

  lock_state_t       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              unlocked_q;
  logic              alarm_q;
  logic              alarm_done;

`ifdef SAFE_LOCK_ALARM_TIMEOUT_EN
  logic alarm_start;

  // Timer restarts on the edge that enters ALARM and runs while there.
  assign alarm_start = (state_q != ALARM) && (state_d == ALARM);

  alarm_hold_timer #(
    .TICKS (ALARM_TICKS)
  ) u_alarm_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .start (alarm_start),
    .run   (state_q == ALARM),
    .done  (alarm_done)
  );
`else
  // Without the timeout, ALARM is held until reset.
  logic unused_alarm_ticks;
  assign unused_alarm_ticks = (ALARM_TICKS != 0);
  assign alarm_done         = 1'b0;
`endif

  // Next-state, password and failure-count decisions.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    fail_cnt_d  = fail_cnt_q;
    err_pulse_d = 1'b0;
    case (state_q)
      LOCKED: begin
        // set_mode is meaningless here: every strobe is an attempt.
        if (key_valid) begin
          if (key_code == code_q) begin
            state_d    = UNLOCKED;
            fail_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (fail_cnt_q >= FAIL_LAST) begin
              state_d    = ALARM;
              fail_cnt_d = FAIL_MAX;
            end else begin
              fail_cnt_d = fail_cnt_q + FAIL_W'(1);
            end
          end
        end
      end
      UNLOCKED: begin
        // A store and a relock in the same cycle both take effect.
        if (key_valid && set_mode) begin
          code_d = key_code;
        end
        if (lock_cmd) begin
          state_d = LOCKED;
        end
      end
      ALARM: begin
        fail_cnt_d = FAIL_MAX;
        if (alarm_done) begin
          state_d    = LOCKED;
          fail_cnt_d = '0;
        end
      end
      default: begin
        state_d    = LOCKED;
        fail_cnt_d = '0;
      end
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOCKED;
      code_q      <= DEFAULT_CODE;
      fail_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      fail_cnt_q  <= fail_cnt_d;
      err_pulse_q <= err_pulse_d;
      unlocked_q  <= (state_d == UNLOCKED);
      alarm_q     <= (state_d == ALARM);
    end
  end

  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign err_pulse = err_pulse_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed, table-driven bench for safe_lock_ctrl (MAX_FAIL=3, ALARM_TICKS=8),
// plus a MAX_FAIL=1 instance for the single-miss boundary.
module tb_safe_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       set_mode = 1'b0;
  logic       lock_cmd = 1'b0;
  logic       unlocked, alarm, err_pulse;
  logic [2:0] fail_cnt;
  logic       unlocked1, alarm1, err_pulse1;
  logic [2:0] fail_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  safe_lock_ctrl #(
    .CODE_W(4), .DEFAULT_CODE(4'b0101), .MAX_FAIL(3), .ALARM_TICKS(8)
  ) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .set_mode(set_mode), .lock_cmd(lock_cmd), .unlocked(unlocked),
    .alarm(alarm), .err_pulse(err_pulse), .fail_cnt(fail_cnt)
  );

  safe_lock_ctrl #(
    .CODE_W(4), .DEFAULT_CODE(4'b0101), .MAX_FAIL(1), .ALARM_TICKS(8)
  ) dut1 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .set_mode(set_mode), .lock_cmd(lock_cmd), .unlocked(unlocked1),
    .alarm(alarm1), .err_pulse(err_pulse1), .fail_cnt(fail_cnt1)
  );

  typedef struct {
    logic       r;
    logic       kv;
    logic [3:0] kc;
    logic       sm;
    logic       lc;
    logic       eu;
    logic       ea;
    logic       ee;
    logic [2:0] ef;
  } vec_t;

  vec_t vec[24];

  // One clock cycle: drive at negedge, sample 1 time unit after posedge.
  task automatic step(input logic r, input logic kv, input logic [3:0] kc,
                      input logic sm, input logic lc);
    @(negedge clk);
    rst = r; key_valid = kv; key_code = kc; set_mode = sm; lock_cmd = lc;
    @(posedge clk);
    #1;
    rst = 1'b0; key_valid = 1'b0; set_mode = 1'b0; lock_cmd = 1'b0;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {unl,alm,err,cnt}=%b_%b_%b_%0d want %b_%b_%b_%0d",
               name, act[5], act[4], act[3], act[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  function automatic logic [5:0] pk(input logic u, input logic a, input logic e, input logic [2:0] f);
    return {u, a, e, f};
  endfunction

  initial begin
    // r  kv  code   sm lc | unl alm err cnt
    vec[0]  = '{1, 0, 4'h0, 0, 0, 0, 0, 0, 3'd0}; // reset
    vec[1]  = '{0, 0, 4'h0, 0, 0, 0, 0, 0, 3'd0}; // idle
    vec[2]  = '{0, 1, 4'h5, 0, 0, 1, 0, 0, 3'd0}; // default code opens
    vec[3]  = '{0, 0, 4'h0, 0, 1, 0, 0, 0, 3'd0}; // relock
    vec[4]  = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 3'd1}; // miss 1
    vec[5]  = '{0, 0, 4'h0, 0, 0, 0, 0, 0, 3'd1}; // err is one cycle, count holds
    vec[6]  = '{0, 1, 4'h2, 0, 0, 0, 0, 1, 3'd2}; // miss 2
    vec[7]  = '{0, 1, 4'h5, 0, 0, 1, 0, 0, 3'd0}; // match clears count
    vec[8]  = '{0, 1, 4'hC, 1, 1, 0, 0, 0, 3'd0}; // store 1100 + relock
    vec[9]  = '{0, 1, 4'h5, 0, 0, 0, 0, 1, 3'd1}; // old code rejected
    vec[10] = '{0, 1, 4'hC, 0, 0, 1, 0, 0, 3'd0}; // new code opens
    vec[11] = '{0, 1, 4'h3, 0, 0, 1, 0, 0, 3'd0}; // plain key in UNLOCKED ignored
    vec[12] = '{0, 0, 4'h0, 0, 1, 0, 0, 0, 3'd0}; // relock
    vec[13] = '{0, 1, 4'hF, 1, 0, 0, 0, 1, 3'd1}; // set_mode in LOCKED = attempt
    vec[14] = '{0, 1, 4'hC, 0, 0, 1, 0, 0, 3'd0}; // password still 1100
    vec[15] = '{1, 0, 4'h0, 0, 0, 0, 0, 0, 3'd0}; // reset mid-UNLOCKED
    vec[16] = '{0, 1, 4'hC, 0, 0, 0, 0, 1, 3'd1}; // code back to 0101
    vec[17] = '{0, 1, 4'h5, 0, 0, 1, 0, 0, 3'd0};
    vec[18] = '{0, 0, 4'h0, 0, 1, 0, 0, 0, 3'd0};
    vec[19] = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 3'd1};
    vec[20] = '{0, 1, 4'h2, 0, 0, 0, 0, 1, 3'd2};
    vec[21] = '{0, 1, 4'h3, 0, 0, 0, 1, 1, 3'd3}; // third miss -> ALARM
    vec[22] = '{0, 1, 4'h5, 0, 0, 0, 1, 0, 3'd3}; // correct key ignored in ALARM
    vec[23] = '{0, 1, 4'h5, 1, 1, 0, 1, 0, 3'd3}; // all inputs ignored in ALARM

    for (int i = 0; i < 24; i++) begin
      step(vec[i].r, vec[i].kv, vec[i].kc, vec[i].sm, vec[i].lc);
      check($sformatf("vec%0d", i), pk(unlocked, alarm, err_pulse, fail_cnt),
            pk(vec[i].eu, vec[i].ea, vec[i].ee, vec[i].ef));
    end

`ifdef SAFE_LOCK_ALARM_TIMEOUT_EN
    // ALARM entered at vec21; 3 alarm cycles seen, 5 more then exit.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'h0, 0, 0);
      check($sformatf("alarm_hold%0d", i), pk(unlocked, alarm, err_pulse, fail_cnt),
            pk(0, 1, 0, 3'd3));
    end
    step(0, 0, 4'h0, 0, 0);
    check("alarm_exit", pk(unlocked, alarm, err_pulse, fail_cnt), pk(0, 0, 0, 3'd0));
    step(0, 1, 4'h5, 0, 0);
    check("open_after_alarm", pk(unlocked, alarm, err_pulse, fail_cnt), pk(1, 0, 0, 3'd0));
`else
    // ALARM is sticky without the timeout.
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 3) == 0, 4'h5, 0, i[0]);
      check($sformatf("alarm_sticky%0d", i), pk(unlocked, alarm, err_pulse, fail_cnt),
            pk(0, 1, 0, 3'd3));
    end
`endif

    // Reset mid-ALARM: re-enter alarm, then reset.
    step(1, 0, 4'h0, 0, 0);
    step(0, 1, 4'h9, 0, 0);
    step(0, 1, 4'h9, 0, 0);
    step(0, 1, 4'h9, 0, 0);
    check("realarm", pk(unlocked, alarm, err_pulse, fail_cnt), pk(0, 1, 1, 3'd3));
    step(0, 0, 4'h0, 0, 0);
    step(1, 1, 4'h5, 0, 0);
    check("rst_mid_alarm", pk(unlocked, alarm, err_pulse, fail_cnt), pk(0, 0, 0, 3'd0));
    step(0, 1, 4'h5, 0, 0);
    check("open_after_rst", pk(unlocked, alarm, err_pulse, fail_cnt), pk(1, 0, 0, 3'd0));

    // MAX_FAIL=1: first miss goes straight to ALARM with err_pulse.
    step(1, 0, 4'h0, 0, 0);
    check("mf1_reset", pk(unlocked1, alarm1, err_pulse1, fail_cnt1), pk(0, 0, 0, 3'd0));
    step(0, 1, 4'h7, 0, 0);
    check("mf1_first_miss", pk(unlocked1, alarm1, err_pulse1, fail_cnt1), pk(0, 1, 1, 3'd1));
    step(0, 1, 4'h5, 0, 0);
    check("mf1_hold", pk(unlocked1, alarm1, err_pulse1, fail_cnt1), pk(0, 1, 0, 3'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
